// File: rtl/mat_matcher_seq_pkg.sv
// rtl/mat_matcher_seq_pkg.sv - shared state encoding, default threshold and clog2 helper
package mat_matcher_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mat_state_t;

  localparam int MAT_THR_DEFAULT = 30;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mat_lane_cmp.sv
// rtl/mat_lane_cmp.sv - one lane: absolute distance of a DB entry to the mean and strict threshold test
module mat_lane_cmp #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] i_entry,
  input  logic [PIX_W-1:0] i_avg,
  input  logic [PIX_W-1:0] i_thr,
  input  logic             i_lane_vld,
  output logic [PIX_W-1:0] o_dist,
  output logic             o_match
);

  logic signed [PIX_W:0] w_diff;
  logic signed [PIX_W:0] w_abs;
  logic                  w_unused_abs_msb;

  // One extra bit keeps the difference signed so the magnitude never wraps.
  assign w_diff           = $signed({1'b0, i_entry}) - $signed({1'b0, i_avg});
  assign w_abs            = w_diff[PIX_W] ? -w_diff : w_diff;
  assign o_dist           = w_abs[PIX_W-1:0];
  assign w_unused_abs_msb = w_abs[PIX_W];
  assign o_match          = i_lane_vld && (o_dist < i_thr);

endmodule

// File: rtl/mat_matcher_seq.sv
// rtl/mat_matcher_seq.sv - sequential FAST9 matcher: neighbour mean vs. streamed DB, count and best entry
module mat_matcher_seq
  import mat_matcher_seq_pkg::*;
#(
  parameter  int PIX_W    = 8,
  parameter  int N_ADJ    = 8,
  parameter  int DB_DEPTH = 36,
  parameter  int LANES    = 4,
  localparam int BEATS    = (DB_DEPTH + LANES - 1) / LANES,
  localparam int ADDR_W   = (BEATS > 1) ? clog2(BEATS) : 1,
  localparam int IDX_W    = (DB_DEPTH > 1) ? clog2(DB_DEPTH) : 1,
  localparam int CNT_W    = clog2(DB_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   early_exit,
  input  logic [N_ADJ*PIX_W-1:0] adj_pixel,
  input  logic [PIX_W-1:0]       threshold,
  output logic                   db_rd_en,
  output logic [ADDR_W-1:0]      db_rd_addr,
  input  logic [LANES*PIX_W-1:0] db_rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   mat_point,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [IDX_W-1:0]       best_idx,
  output logic [PIX_W-1:0]       best_dist
);

  localparam int                LOG_N     = clog2(N_ADJ);
  localparam int                SUM_W     = PIX_W + LOG_N;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BEATS - 1);

  mat_state_t        r_state;
  mat_state_t        w_next;
  logic [PIX_W-1:0]  r_avg;
  logic [PIX_W-1:0]  r_thr;
  logic              r_early;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_beat;
  logic              r_vld;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_best_idx;
  logic [PIX_W-1:0]  r_best_dist;

  logic [SUM_W-1:0]  w_sum;
  logic [PIX_W-1:0]  w_avg;
  logic              w_unused_sum_lsb;
  logic [PIX_W-1:0]  w_dist [LANES];
  logic [LANES-1:0]  w_match;
  logic [LANES-1:0]  w_lane_vld;
  logic [CNT_W-1:0]  w_pop;
  logic              w_bm_any;
  logic [PIX_W-1:0]  w_bm_dist;
  logic [IDX_W-1:0]  w_bm_idx;
  logic              w_acc;
  logic              w_hit;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_ADJ; i++) begin
      w_sum = w_sum + SUM_W'(adj_pixel[i*PIX_W +: PIX_W]);
    end
  end

  // Floor mean: drop the log2(N_ADJ) fraction bits of the widened sum.
  assign w_avg            = w_sum[SUM_W-1:LOG_N];
  assign w_unused_sum_lsb = ^w_sum[LOG_N-1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_vld[g] = (int'(r_beat) * LANES + g) < DB_DEPTH;

    mat_lane_cmp #(
      .PIX_W(PIX_W)
    ) u_cmp (
      .i_entry   (db_rd_data[g*PIX_W +: PIX_W]),
      .i_avg     (r_avg),
      .i_thr     (r_thr),
      .i_lane_vld(w_lane_vld[g]),
      .o_dist    (w_dist[g]),
      .o_match   (w_match[g])
    );
  end

  // Best-of-beat: ascending lane order with strict compare keeps the lowest index on ties.
  always_comb begin
    w_pop     = '0;
    w_bm_any  = 1'b0;
    w_bm_dist = '1;
    w_bm_idx  = '0;
    for (int j = 0; j < LANES; j++) begin
      w_pop = w_pop + CNT_W'(w_match[j]);
      if (w_lane_vld[j] && (!w_bm_any || (w_dist[j] < w_bm_dist))) begin
        w_bm_any  = 1'b1;
        w_bm_dist = w_dist[j];
        w_bm_idx  = IDX_W'(int'(r_beat) * LANES + j);
      end
    end
  end

  // Returning data is only consumed while scanning; the read trailing an early exit lands in DONE.
  assign w_acc = r_vld && ((r_state == ST_SCAN) || (r_state == ST_DRAIN));
  assign w_hit = w_acc && r_early && (w_pop != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_hit) begin
          w_next = ST_DONE;
        end else if (r_addr == ADDR_LAST) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    db_rd_en = (r_state == ST_SCAN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avg       <= '0;
      r_thr       <= '0;
      r_early     <= 1'b0;
      r_addr      <= '0;
      r_beat      <= '0;
      r_vld       <= 1'b0;
      r_cnt       <= '0;
      r_best_idx  <= '0;
      r_best_dist <= '1;
    end else begin
      r_vld <= db_rd_en;
      if (db_rd_en) r_beat <= r_addr;
      if ((r_state == ST_IDLE) && start) begin
        r_avg       <= w_avg;
        r_thr       <= threshold;
        r_early     <= early_exit;
        r_addr      <= '0;
        r_cnt       <= '0;
        r_best_idx  <= '0;
        r_best_dist <= '1;
      end else begin
        if ((r_state == ST_SCAN) && (r_addr != ADDR_LAST)) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
        if (w_acc) begin
          r_cnt <= r_cnt + w_pop;
          if (w_bm_any && (w_bm_dist < r_best_dist)) begin
            r_best_dist <= w_bm_dist;
            r_best_idx  <= w_bm_idx;
          end
        end
      end
    end
  end

  assign db_rd_addr = r_addr;
  assign match_cnt  = r_cnt;
  assign mat_point  = (r_cnt != '0);
  assign best_idx   = r_best_idx;
  assign best_dist  = r_best_dist;

endmodule
